// File: rtl/stream_upsizer.sv
// Narrow-to-wide stream packer: SCALE beats of DW_IN bits become one word, first beat in lane 0.
// Optional TLAST/TKEEP handling is enabled with `define STREAM_UPSIZER_LAST_EN.

module stream_upsizer_lane #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel_i,
  input  logic          below_i,
  input  logic          wr_i,
  input  logic          wrap_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] out_o
);
  logic [DW-1:0] acc_q, acc_d, out_q, out_d;

  always_comb begin
    acc_d = acc_q;
    out_d = out_q;
    if (wr_i && sel_i) acc_d = data_i;
    // Lanes above the wrap point are zeroed, which only occurs on an early (last) wrap.
    if (wrap_i) out_d = sel_i ? data_i : (below_i ? acc_q : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;
endmodule

module stream_upsizer #(
  parameter int DW_IN = 8,
  parameter int SCALE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DW_IN-1:0]       s_data_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  output logic [DW_IN*SCALE-1:0] m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i
`ifdef STREAM_UPSIZER_LAST_EN
  ,
  input  logic                   s_last_i,
  output logic                   m_last_o,
  output logic [SCALE-1:0]       m_keep_o
`endif
);
  localparam int IW = (SCALE > 1) ? $clog2(SCALE) : 1;

  logic [IW-1:0]                idx_q, idx_d;
  logic                         full_q, full_d;
  logic                         rst_r_q, rst_r_d;
  logic [SCALE-1:0]             sel, below;
  logic [SCALE-1:0][DW_IN-1:0]  out_lanes;
  logic                         wrap_cond, wr, rd, wrap;

  always_comb begin
    sel   = '0;
    below = '0;
    for (int i = 0; i < SCALE; i++) begin
      sel[i]   = (idx_q == IW'(i));
      below[i] = (IW'(i) < idx_q);
    end
  end

`ifdef STREAM_UPSIZER_LAST_EN
  assign wrap_cond = (idx_q == IW'(SCALE-1)) | s_last_i;
`else
  assign wrap_cond = (idx_q == IW'(SCALE-1));
`endif

  // The wrap beat may enter in the same cycle the held word drains.
  assign s_ready_o = !rst_r_q & (!wrap_cond | !full_q | m_ready_i);
  assign wr        = s_valid_i & s_ready_o;
  assign rd        = full_q & m_ready_i;
  assign wrap      = wr & wrap_cond;

  always_comb begin
    rst_r_d = 1'b0;
    idx_d   = idx_q;
    full_d  = full_q;
    if (wrap)    idx_d = '0;
    else if (wr) idx_d = idx_q + IW'(1);
    if (wrap)    full_d = 1'b1;
    else if (rd) full_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_r_q <= 1'b1;
      idx_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      rst_r_q <= rst_r_d;
      idx_q   <= idx_d;
      full_q  <= full_d;
    end
  end

  for (genvar g = 0; g < SCALE; g++) begin : g_lane
    stream_upsizer_lane #(.DW(DW_IN)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .sel_i   (sel[g]),
      .below_i (below[g]),
      .wr_i    (wr),
      .wrap_i  (wrap),
      .data_i  (s_data_i),
      .out_o   (out_lanes[g])
    );
  end

  assign m_data_o  = out_lanes;
  assign m_valid_o = full_q;

`ifdef STREAM_UPSIZER_LAST_EN
  logic             last_q, last_d;
  logic [SCALE-1:0] keep_q, keep_d;

  always_comb begin
    last_d = last_q;
    keep_d = keep_q;
    if (wrap) begin
      last_d = s_last_i;
      keep_d = sel | below;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b0;
      keep_q <= '0;
    end else begin
      last_q <= last_d;
      keep_q <= keep_d;
    end
  end

  assign m_last_o = last_q;
  assign m_keep_o = keep_q;
`endif
endmodule

// File: tb/tb_stream_upsizer.sv
// Bench for stream_upsizer: 8x4 instance with word scoreboard, plus a 16x1 instance.
module tb_stream_upsizer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready_o;
  logic [31:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready = 1'b0;

  logic [15:0] s1_data = '0;
  logic        s1_valid = 1'b0;
  logic        s1_ready_o;
  logic [15:0] m1_data_o;
  logic        m1_valid_o;
  logic        m1_ready = 1'b1;

`ifdef STREAM_UPSIZER_LAST_EN
  logic        s_last = 1'b0;
  logic        m_last_o;
  logic [3:0]  m_keep_o;
  logic        s1_last = 1'b0;
  logic        m1_last_o;
  logic [0:0]  m1_keep_o;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_waits = 0;
  logic [31:0] sb[$];
  int out_times[$];

  stream_upsizer #(.DW_IN(8), .SCALE(4)) u_dut (
    .clk(clk), .rst(rst), .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready)
`ifdef STREAM_UPSIZER_LAST_EN
    , .s_last_i(s_last), .m_last_o(m_last_o), .m_keep_o(m_keep_o)
`endif
  );

  stream_upsizer #(.DW_IN(16), .SCALE(1)) u_dut1 (
    .clk(clk), .rst(rst), .s_data_i(s1_data), .s_valid_i(s1_valid), .s_ready_o(s1_ready_o),
    .m_data_o(m1_data_o), .m_valid_o(m1_valid_o), .m_ready_i(m1_ready)
`ifdef STREAM_UPSIZER_LAST_EN
    , .s_last_i(s1_last), .m_last_o(m1_last_o), .m_keep_o(m1_keep_o)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: each negedge with valid&ready is one word transferred at the next posedge.
  always @(negedge clk) begin
    if (!rst && m_valid_o && m_ready) begin
      checks++;
      out_times.push_back(cyc);
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got=%h expected=none", m_data_o);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (m_data_o !== e) begin
          errors++;
          $display("FAIL sb_word got=%h expected=%h", m_data_o, e);
        end
      end
    end
  end

  task automatic drive_beat(input logic [7:0] d);
    int w;
    w = 0;
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    while (!s_ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready_o) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout data=%h ready=%b expected ready=1", d, s_ready_o);
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
    last_waits = w;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    checks++;
    if (m_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b expected=0", m_valid_o); end
    checks++;
    if (s_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b expected=0", s_ready_o); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready_o !== 1'b0) begin errors++; $display("FAIL rst_hold_ready got=%b expected=0", s_ready_o); end
    @(negedge clk);
    checks++;
    if (s_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b expected=1", s_ready_o); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    m_ready = 1'b1;
    sb.push_back(32'h44332211);
    drive_beat(8'h11);
    drive_beat(8'h22);
    drive_beat(8'h33);
    drive_beat(8'h44);
    @(negedge clk);
    checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 32'h44332211) begin
      errors++; $display("FAIL basic_word valid=%b data=%h expected 1/44332211", m_valid_o, m_data_o);
    end
    @(negedge clk);
    checks++;
    if (m_valid_o !== 1'b0) begin errors++; $display("FAIL basic_pulse valid=%b expected=0", m_valid_o); end
    idle(1);
  endtask

  task automatic test_stream();
    int stalls;
    stalls = 0;
    m_ready = 1'b1;
    out_times.delete();
    sb.push_back(32'h44332211);
    sb.push_back(32'h88776655);
    for (int i = 1; i <= 8; i++) begin
      drive_beat(8'(i * 8'h11));
      stalls += last_waits;
    end
    idle(3);
    checks++;
    if (stalls !== 0) begin errors++; $display("FAIL stream_stalls got=%0d expected=0", stalls); end
    checks++;
    if (out_times.size() !== 2) begin
      errors++; $display("FAIL stream_count got=%0d expected=2", out_times.size());
    end else if (out_times[1] - out_times[0] !== 4) begin
      errors++; $display("FAIL stream_spacing got=%0d expected=4", out_times[1] - out_times[0]);
    end
  endtask

  task automatic test_backpressure();
    int stalls;
    stalls = 0;
    m_ready = 1'b0;
    sb.push_back(32'h44332211);
    sb.push_back(32'h88776655);
    for (int i = 1; i <= 7; i++) begin
      drive_beat(8'(i * 8'h11));
      stalls += last_waits;
    end
    checks++;
    if (stalls !== 0) begin errors++; $display("FAIL bp_accept7 stalls=%0d expected=0", stalls); end
    s_valid = 1'b1;
    s_data  = 8'h88;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (s_ready_o !== 1'b0 || m_valid_o !== 1'b1 || m_data_o !== 32'h44332211) begin
        errors++;
        $display("FAIL bp_hold ready=%b valid=%b data=%h expected 0/1/44332211", s_ready_o, m_valid_o, m_data_o);
      end
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready_o !== 1'b1) begin errors++; $display("FAIL bp_same_cycle ready=%b expected=1", s_ready_o); end
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 32'h88776655) begin
      errors++; $display("FAIL bp_second valid=%b data=%h expected 1/88776655", m_valid_o, m_data_o);
    end
    idle(2);
  endtask

  task automatic test_async_reset();
    // A held word plus two packed lanes must all be discarded.
    m_ready = 1'b0;
    drive_beat(8'hC1); drive_beat(8'hC2); drive_beat(8'hC3); drive_beat(8'hC4);
    drive_beat(8'h01); drive_beat(8'h02);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (m_valid_o !== 1'b0 || s_ready_o !== 1'b0) begin
      errors++; $display("FAIL arst_immediate valid=%b ready=%b expected 0/0", m_valid_o, s_ready_o);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready_o !== 1'b0) begin errors++; $display("FAIL arst_hold_ready got=%b expected=0", s_ready_o); end
    @(posedge clk);
    #1;
    sb.push_back(32'hA4A3A2A1);
    drive_beat(8'hA1); drive_beat(8'hA2); drive_beat(8'hA3); drive_beat(8'hA4);
    @(negedge clk);
    checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 32'hA4A3A2A1) begin
      errors++; $display("FAIL arst_word valid=%b data=%h expected 1/A4A3A2A1", m_valid_o, m_data_o);
    end
    idle(2);
  endtask

  task automatic test_scale1();
    m1_ready = 1'b1;
    s1_valid = 1'b1;
    s1_data  = 16'hBEEF;
    @(negedge clk);
    checks++;
    if (s1_ready_o !== 1'b1) begin errors++; $display("FAIL s1_ready got=%b expected=1", s1_ready_o); end
    @(posedge clk);
    #1 s1_data = 16'hCAFE;
    @(negedge clk);
    checks++;
    if (m1_valid_o !== 1'b1 || m1_data_o !== 16'hBEEF || s1_ready_o !== 1'b1) begin
      errors++; $display("FAIL s1_first valid=%b data=%h ready=%b expected 1/BEEF/1", m1_valid_o, m1_data_o, s1_ready_o);
    end
    @(posedge clk);
    #1 s1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (m1_valid_o !== 1'b1 || m1_data_o !== 16'hCAFE) begin
      errors++; $display("FAIL s1_second valid=%b data=%h expected 1/CAFE", m1_valid_o, m1_data_o);
    end
    @(negedge clk);
    checks++;
    if (m1_valid_o !== 1'b0) begin errors++; $display("FAIL s1_drain valid=%b expected=0", m1_valid_o); end
    idle(1);
  endtask

`ifdef STREAM_UPSIZER_LAST_EN
  task automatic test_last();
    m_ready = 1'b1;
    sb.push_back(32'h0000BBAA);
    drive_beat(8'hAA);
    s_last = 1'b1;
    drive_beat(8'hBB);
    s_last = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 32'h0000BBAA || m_keep_o !== 4'b0011 || m_last_o !== 1'b1) begin
      errors++;
      $display("FAIL last_short valid=%b data=%h keep=%b last=%b expected 1/0000BBAA/0011/1", m_valid_o, m_data_o, m_keep_o, m_last_o);
    end
    sb.push_back(32'h44332211);
    drive_beat(8'h11); drive_beat(8'h22); drive_beat(8'h33); drive_beat(8'h44);
    @(negedge clk);
    checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 32'h44332211 || m_keep_o !== 4'b1111 || m_last_o !== 1'b0) begin
      errors++;
      $display("FAIL last_full valid=%b data=%h keep=%b last=%b expected 1/44332211/1111/0", m_valid_o, m_data_o, m_keep_o, m_last_o);
    end
    idle(2);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_backpressure();
    test_async_reset();
    test_scale1();
`ifdef STREAM_UPSIZER_LAST_EN
    test_last();
`endif
    idle(2);
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL sb_leftover got=%0d expected=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
